// File: rtl/fifo_cmd_sequencer.sv
// rtl/fifo_cmd_sequencer.sv - executes decoded host command frames against the byte FIFO and UART TX
//
// Purpose: runs one WRITE / READ / CLEAR command per frame and ends every
// command, successful or aborted, with a single-cycle fifo_done pulse that
// re-arms the frame decoder.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   frame_valid        one-cycle pulse, cmd/rx_cnt hold a complete frame
//   cmd, rx_cnt        opcode (01 WRITE, 02 READ, 03 CLEAR) and byte count
//   rok, mosi          UART receive byte strobe and data
//   fifo_full/empty    FIFO status
//   fifo_rdata         FIFO read data, valid the cycle after the pop
//   fifo_wr/wdata      FIFO push strobe and data
//   fifo_rd            FIFO pop strobe
//   fifo_clr           FIFO synchronous flush
//   tx_start/tx_data   UART TX launch strobe and byte
//   tx_busy            UART TX shifting, rises the cycle after tx_start
//   fifo_done          one-cycle command-complete pulse
//   busy               sequencer is not idle
//   err                sticky error, cleared by the next accepted frame
`timescale 1ns/1ps

module fifo_cmd_sequencer #(
  parameter int          CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16'd50000,
  parameter int          TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  input  logic [7:0]       cmd,
  input  logic [CNT_W-1:0] rx_cnt,
  input  logic             rok,
  input  logic [7:0]       mosi,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_wr,
  output logic [7:0]       fifo_wdata,
  output logic             fifo_rd,
  output logic             fifo_clr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             fifo_done,
  output logic             busy,
  output logic             err
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  // The abort fires on the cycle whose increment would bring the idle
  // counter up to TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_DATA,
    S_TX_WAIT,
    S_CLR,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [7:0]       fifo_wdata_q, fifo_wdata_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             fifo_clr_q, fifo_clr_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             fifo_done_q, fifo_done_d;
  logic             busy_q, busy_d;

  logic             to_expired;
  logic             to_restart;

  assign to_expired = (to_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    err_d        = err_q;
    fifo_wdata_d = fifo_wdata_q;
    tx_data_d    = tx_data_q;
    fifo_wr_d    = 1'b0;
    fifo_rd_d    = 1'b0;
    tx_start_d   = 1'b0;
    to_restart   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          remaining_d = rx_cnt;
          err_d       = 1'b0;
          case (cmd)
            OP_WRITE: state_d = (rx_cnt == '0) ? S_DONE : S_WR_WAIT;
            OP_READ:  state_d = (rx_cnt == '0) ? S_DONE : S_RD_REQ;
            OP_CLEAR: state_d = S_CLR;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_WR_WAIT: begin
        if (rok) begin
          // Every received byte counts against the transfer, even one
          // dropped because the FIFO is full.
          to_restart = 1'b1;
          if (fifo_full) begin
            err_d = 1'b1;
          end else begin
            fifo_wr_d    = 1'b1;
            fifo_wdata_d = mosi;
          end
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if (remaining_q <= CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end else if (to_expired) begin
          err_d       = 1'b1;
          remaining_d = '0;
          state_d     = S_DONE;
        end
      end

      S_RD_REQ: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_rd_d = 1'b1;
          state_d   = S_RD_DATA;
        end else if (to_expired) begin
          err_d       = 1'b1;
          remaining_d = '0;
          state_d     = S_DONE;
        end
      end

      S_RD_DATA: begin
        // fifo_rd_q is high only on the first RD_DATA cycle; the FIFO pops
        // on the edge ending that cycle, so its data is captured one later.
        if (!fifo_rd_q) begin
          tx_data_d  = fifo_rdata;
          tx_start_d = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          state_d = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // tx_start_q marks the first TX_WAIT cycle, before the transmitter
        // has had a chance to raise tx_busy; tx_busy is ignored there.
        if (!tx_start_q && !tx_busy) begin
          state_d = (remaining_q == '0) ? S_DONE : S_RD_REQ;
        end
      end

      S_CLR: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A frame arriving mid-command is dropped and flagged; the running
    // command carries on untouched.
    if (frame_valid && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    // Idle-wait counter: only runs in the two states that wait on the
    // outside world, and restarts on any progress.
    if ((state_d != state_q) || to_restart) begin
      to_d = '0;
    end else if ((state_q == S_WR_WAIT) || (state_q == S_RD_REQ)) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = '0;
    end

    // Moore-style strobes registered on entry to the state they belong to.
    fifo_clr_d  = (state_d == S_CLR);
    fifo_done_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      to_q         <= '0;
      err_q        <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= 8'h00;
      fifo_rd_q    <= 1'b0;
      fifo_clr_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      fifo_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      to_q         <= to_d;
      err_q        <= err_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_clr_q   <= fifo_clr_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      fifo_done_q  <= fifo_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_wr    = fifo_wr_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_rd    = fifo_rd_q;
  assign fifo_clr   = fifo_clr_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign fifo_done  = fifo_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fifo_cmd_sequencer.sv
// tb/tb_fifo_cmd_sequencer.sv - self-checking bench for fifo_cmd_sequencer
`timescale 1ns/1ps

module tb_fifo_cmd_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_valid;
  logic [7:0] cmd;
  logic [7:0] rx_cnt;
  logic       rok;
  logic [7:0] mosi;
  logic       fifo_full;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       tx_busy = 1'b0;
  logic       fifo_wr, fifo_rd, fifo_clr, tx_start, fifo_done, busy, err;
  logic [7:0] fifo_wdata, tx_data;

  always #5 clk = ~clk;

  fifo_cmd_sequencer #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .TO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .cmd(cmd),
    .rx_cnt(rx_cnt), .rok(rok), .mosi(mosi), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .fifo_rd(fifo_rd), .fifo_clr(fifo_clr),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .fifo_done(fifo_done), .busy(busy), .err(err)
  );

  // FIFO + UART TX models and event logs, all sampled on the falling edge.
  logic [7:0] fq[$];
  logic [7:0] wr_log[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  logic [7:0] rd_next = 8'h00;
  int         cyc = 0;
  int         tx_cnt = 0;
  bit         tx_pend = 1'b0;
  int         done_cnt = 0, done_cyc = 0, rd_cnt = 0, clr_cnt = 0, start_viol = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (fifo_wr) begin
        wr_log.push_back(fifo_wdata);
        if (!fifo_full) fq.push_back(fifo_wdata);
      end
      if (fifo_rd) begin
        rd_cnt = rd_cnt + 1;
        if (fq.size() > 0) rd_next = fq.pop_front();
        else rd_next = 8'hEE;
      end
      if (fifo_clr) begin
        clr_cnt = clr_cnt + 1;
        fq.delete();
      end
      if (fifo_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
      if (tx_pend) begin
        tx_cnt  = 10;
        tx_pend = 1'b0;
      end
      if (tx_start) begin
        if (tx_busy) start_viol = start_viol + 1;
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
        tx_pend = 1'b1;
      end
      tx_busy    = (tx_cnt > 0);
      fifo_empty = (fq.size() == 0);
    end
  end

  // Registered FIFO read port: data popped in the fifo_rd cycle appears
  // after the following rising edge.
  initial begin
    forever begin
      @(posedge clk);
      fifo_rdata <= rd_next;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk = n_chk + 1;
    if (act >= lo && act <= hi) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] n, output int fcyc);
    cmd         = c;
    rx_cnt      = n;
    frame_valid = 1'b1;
    fcyc        = cyc;
    step();
    frame_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mosi = b;
    rok  = 1'b1;
    step();
    rok  = 1'b0;
    step();
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n = n + 1;
    end
    chk({name, " done seen"}, int'(done_cnt > base), 1);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] cnt;
    int         lat;
    int         err;
    int         clr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f, base, w0, r0, t0, c0, n;
    logic [7:0] exp_wr[3];

    vecs[0] = '{8'h03, 8'h05, 2, 0, 1};
    vecs[1] = '{8'h7F, 8'h00, 1, 1, 0};
    vecs[2] = '{8'h01, 8'h00, 1, 0, 0};
    vecs[3] = '{8'h00, 8'h03, 1, 1, 0};
    vecs[4] = '{8'h02, 8'h00, 1, 0, 0};
    vecs[5] = '{8'hFF, 8'h01, 1, 1, 0};
    exp_wr[0] = 8'hA5;
    exp_wr[1] = 8'h5A;
    exp_wr[2] = 8'h3C;

    rst_n = 1'b0; frame_valid = 1'b0; cmd = 8'h00; rx_cnt = 8'h00;
    rok = 1'b0; mosi = 8'h00; fifo_full = 1'b0;
    step(); step();
    chk("reset outputs", int'({fifo_wr, fifo_wdata, fifo_rd, fifo_clr, tx_start,
                               tx_data, fifo_done, busy, err}), 0);
    rst_n = 1'b1;
    step(); step();
    chk("post-reset outputs", int'({fifo_wr, fifo_wdata, fifo_rd, fifo_clr, tx_start,
                                    tx_data, fifo_done, busy, err}), 0);

    // Single-frame commands from the table.
    for (int i = 0; i < 6; i++) begin
      base = done_cnt; w0 = wr_log.size(); r0 = rd_cnt; t0 = tx_log.size(); c0 = clr_cnt;
      send_frame(vecs[i].cmd, vecs[i].cnt, f);
      wait_done(base, 10, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d latency", i), done_cyc - f, vecs[i].lat);
      chk($sformatf("vec%0d err", i), int'(err), vecs[i].err);
      chk($sformatf("vec%0d clr pulses", i), clr_cnt - c0, vecs[i].clr);
      chk($sformatf("vec%0d traffic", i), (wr_log.size() - w0) + (rd_cnt - r0) + (tx_log.size() - t0), 0);
      step();
      chk($sformatf("vec%0d idle", i), int'({busy, fifo_done}), 0);
      chk($sformatf("vec%0d done count", i), done_cnt - base, 1);
    end

    // rok while idle belongs to the decoder.
    w0 = wr_log.size();
    send_byte(8'h55);
    chk("idle rok ignored", wr_log.size() - w0, 0);

    // WRITE of three bytes.
    base = done_cnt; w0 = wr_log.size();
    send_frame(8'h01, 8'd3, f);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h3C);
    wait_done(base, 10, "write3");
    chk("write3 count", wr_log.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      if (wr_log.size() > w0 + i) chk($sformatf("write3 data%0d", i), wr_log[w0 + i], exp_wr[i]);
    end
    chk("write3 err", int'(err), 0);

    // Flush, preload 0x11 0x22, then READ 2 through the slow transmitter.
    base = done_cnt;
    send_frame(8'h03, 8'd0, f);
    wait_done(base, 10, "clear");
    step();
    chk("clear empties fifo", int'(fifo_empty), 1);
    base = done_cnt;
    send_frame(8'h01, 8'd2, f);
    send_byte(8'h11); send_byte(8'h22);
    wait_done(base, 10, "preload");
    step();
    base = done_cnt; r0 = rd_cnt; t0 = tx_log.size();
    send_frame(8'h02, 8'd2, f);
    wait_done(base, 100, "read2");
    step(); step(); step();
    chk("read2 tx count", tx_log.size() - t0, 2);
    if (tx_log.size() >= t0 + 2) begin
      chk("read2 byte0", tx_log[t0], 8'h11);
      chk("read2 byte1", tx_log[t0 + 1], 8'h22);
      chk_range("read2 start gap", tx_cyc[t0 + 1] - tx_cyc[t0], 12, 1000);
    end
    chk("read2 start while busy", start_viol, 0);
    chk("read2 pops", rd_cnt - r0, 2);
    chk("read2 single done", done_cnt - base, 1);
    chk("read2 err", int'(err), 0);

    // Frame arriving mid-READ: flagged, READ still completes.
    base = done_cnt;
    send_frame(8'h01, 8'd1, f);
    send_byte(8'h77);
    wait_done(base, 10, "preload1");
    step();
    base = done_cnt; t0 = tx_log.size(); c0 = clr_cnt;
    send_frame(8'h02, 8'd1, f);
    n = 0;
    while (!tx_busy && n < 40) begin
      step();
      n = n + 1;
    end
    chk("midread tx busy seen", int'(tx_busy), 1);
    send_frame(8'h03, 8'd0, f);
    chk("midread err", int'(err), 1);
    wait_done(base, 50, "midread");
    step(); step();
    chk("midread tx byte", (tx_log.size() > t0) ? int'(tx_log[t0]) : -1, 8'h77);
    chk("midread no clear", clr_cnt - c0, 0);
    chk("midread single done", done_cnt - base, 1);
    chk("midread err sticky", int'(err), 1);

    // READ against a permanently empty FIFO times out.
    base = done_cnt; r0 = rd_cnt;
    send_frame(8'h02, 8'd1, f);
    wait_done(base, 120, "timeout");
    chk_range("timeout latency", done_cyc - f, 100, 102);
    chk("timeout err", int'(err), 1);
    chk("timeout no pop", rd_cnt - r0, 0);
    step();

    // WRITE into a full FIFO drops bytes but still counts them.
    fifo_full = 1'b1;
    base = done_cnt; w0 = wr_log.size();
    send_frame(8'h01, 8'd2, f);
    send_byte(8'hC1);
    chk("full no early done", done_cnt - base, 0);
    send_byte(8'hC2);
    wait_done(base, 10, "full");
    chk("full no push", wr_log.size() - w0, 0);
    chk("full err", int'(err), 1);
    fifo_full = 1'b0;
    step();
    base = done_cnt;
    send_frame(8'h01, 8'd0, f);
    chk("new frame clears err", int'(err), 0);
    wait_done(base, 10, "after full");
    step();

    // Reset in the middle of a WRITE: straight back to idle, no done.
    base = done_cnt;
    send_frame(8'h01, 8'd5, f);
    send_byte(8'h99);
    chk("midwrite busy", int'(busy), 1);
    rst_n = 1'b0;
    step();
    chk("midreset outputs", int'({fifo_wr, fifo_wdata, fifo_rd, fifo_clr, tx_start,
                                  tx_data, fifo_done, busy, err}), 0);
    rst_n = 1'b1;
    step(); step();
    chk("midreset no done", done_cnt - base, 0);
    chk("midreset idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_cmd_sequencer.md
Name: fifo_cmd_sequencer

Overview:
Executes host command frames (opcode plus byte count) decoded from the UART receive stream.
- WRITE: moves the following UART bytes into the data FIFO.
- READ: drains FIFO bytes to the UART transmitter.
- CLEAR: flushes the FIFO.
It sits between the frame decoder, the byte FIFO and the UART TX. At the end of every command it returns a one-cycle fifo_done, which re-arms the decoder.

Parameters:
CNT_W, 8, width of byte count and remaining-count register
TIMEOUT, 16'd50000, max idle wait cycles in WR_WAIT/RD_REQ before abort
TO_W, 16, width of timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
frame_valid  in  1  one-cycle pulse: cmd/rx_cnt hold a complete frame
cmd  in  8  opcode: 8'h01 WRITE, 8'h02 READ, 8'h03 CLEAR
rx_cnt  in  CNT_W  byte count for WRITE/READ
rok  in  1  UART byte strobe
mosi  in  8  UART received byte, valid with rok
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
fifo_rdata  in  8  FIFO read data, valid 1 cycle after fifo_rd
fifo_wr  out  1  FIFO push strobe
fifo_wdata  out  8  FIFO push data
fifo_rd  out  1  FIFO pop strobe
fifo_clr  out  1  FIFO synchronous flush
tx_start  out  1  UART TX start pulse
tx_data  out  8  UART TX byte, valid with tx_start
tx_busy  in  1  TX shifting; rises cycle after tx_start
fifo_done  out  1  one-cycle command-complete pulse
busy  out  1  high whenever state != IDLE
err  out  1  sticky error flag

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE.
  - All outputs 0, including fifo_wdata and tx_data.
  - remaining=0, timeout counter=0.
- States: IDLE, WR_WAIT, RD_REQ, RD_DATA, TX_WAIT, CLR, DONE.
- All outputs are registered. Strobes are exactly one cycle wide.
- IDLE:
  - On frame_valid: latch remaining<=rx_cnt, clear err, then branch on cmd.
  - 01 -> WR_WAIT. 02 -> RD_REQ. 03 -> CLR. Any other opcode -> err<=1, go to DONE.
  - WRITE/READ with rx_cnt==0 -> DONE directly, no FIFO or TX traffic.
- WR_WAIT:
  - On rok with !fifo_full: fifo_wr=1 and fifo_wdata=mosi in the next cycle.
  - On rok with fifo_full: byte dropped, err<=1, no push.
  - Either way, each rok decrements remaining. When remaining reaches 0 -> DONE.
- RD_REQ:
  - If !fifo_empty and !tx_busy: fifo_rd=1 next cycle -> RD_DATA.
  - Otherwise stay in RD_REQ.
- RD_DATA: capture fifo_rdata into tx_data, pulse tx_start, decrement remaining -> TX_WAIT.
- TX_WAIT:
  - First cycle unconditional (guard for the tx_busy rise).
  - Then wait for tx_busy==0. Exit to DONE if remaining==0, else RD_REQ.
- CLR: fifo_clr=1 for one cycle -> DONE.
- DONE: fifo_done=1 for one cycle -> IDLE.
- Timeout:
  - Counter resets on every state change and on each rok in WR_WAIT.
  - It increments while in WR_WAIT or RD_REQ.
  - On reaching TIMEOUT: err<=1, go to DONE. remaining is discarded.
- frame_valid while busy: ignored, err<=1, and the current command continues.
- rok outside WR_WAIT: ignored. Those bytes belong to the frame decoder.
- remaining is an unsigned CNT_W-bit value; max transfer is 2^CNT_W-1 bytes. No wrap: decrement only when remaining>0.
- Reset mid-command: immediate return to IDLE with no fifo_done. The FIFO is left as-is.

Test Plan:
- Reset -> all outputs 0 and busy=0. Then frame cmd=03 -> fifo_clr pulse, fifo_done pulse 1 cycle later, busy back to 0.
- cmd=01, rx_cnt=3, then rok with 0xA5, 0x5A, 0x3C -> exactly 3 fifo_wr pulses with those data in order, then fifo_done, err=0.
- Preload FIFO with 0x11, 0x22. Send cmd=02, rx_cnt=2; TX model holds tx_busy high for 10 cycles per byte. Required: tx_data 0x11 then 0x22; tx_start only after tx_busy falls; single fifo_done.
- cmd=02, rx_cnt=1 with FIFO empty forever, TIMEOUT=100 -> err=1, fifo_done within 102 cycles, no fifo_rd.
- cmd=01, rx_cnt=2 with fifo_full=1 -> no fifo_wr, err=1, fifo_done after 2nd rok. Then a new frame clears err.
- cmd=8'h7F -> err=1 and fifo_done next cycle. Separately: frame_valid mid-READ -> err=1 and the READ completes normally.
